fp_align_pipe: RTL and testbench

FP_ALIGN_PIPE -- requirements
Module: fp_align_pipe

---
 rtl/fp_align_pipe.sv | 181 ++++++++++++++++++
 tb/tb_fp_align_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_pipe.sv
// fp_align_pipe: two-stage floating-point operand alignment pipeline.
// Stage 1 orders the operands by magnitude and computes the saturated
// exponent difference; stage 2 right-shifts the smaller mantissa and
// folds the shifted-out bits into the sticky position (bit 0).
module fp_align_pipe #(
    parameter  int unsigned EW = 8,
    parameter  int unsigned MW = 28,
    localparam int unsigned DW = 1 + EW + MW,
    localparam int unsigned SW = $clog2(MW + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    input  logic          op_sub,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          sa,
    output logic          sb,
    output logic          comp,
    output logic          eff_sub,
    output logic [EW-1:0] enor,
    output logic [MW-1:0] m_max,
    output logic [MW-1:0] m_aln,
    output logic [SW-1:0] dexp
);

    localparam logic [EW:0]   MW_E = (EW + 1)'(MW);
    localparam logic [SW-1:0] MW_S = SW'(MW);

    // Operand fields
    logic          sign_a_c;
    logic          sign_b_c;
    logic [EW-1:0] ea_c;
    logic [EW-1:0] eb_c;
    logic [MW-1:0] ma_c;
    logic [MW-1:0] mb_c;

    assign sign_a_c = op_a[DW-1];
    assign sign_b_c = op_b[DW-1] ^ op_sub;
    assign ea_c     = op_a[DW-2:MW];
    assign eb_c     = op_b[DW-2:MW];
    assign ma_c     = op_a[MW-1:0];
    assign mb_c     = op_b[MW-1:0];

    // Stage 1 state
    logic          s1_valid;
    logic          s1_sa;
    logic          s1_sb;
    logic          s1_comp;
    logic [EW-1:0] s1_enor;
    logic [MW-1:0] s1_mmax;
    logic [MW-1:0] s1_mmin;
    logic [SW-1:0] s1_dexp;

    // Stage 2 state (drives the outputs)
    logic          s2_valid;

    // Handshake
    logic s1_adv;
    logic s2_adv;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Magnitude compare, operand select and saturated exponent difference
    logic          comp_c;
    logic [EW:0]   diff_c;
    logic [SW-1:0] dexp_sat_c;
    logic [EW-1:0] enor_c;
    logic [MW-1:0] mmax_c;
    logic [MW-1:0] mmin_c;

    always_comb begin
        comp_c     = 1'b0;
        diff_c     = '0;
        dexp_sat_c = '0;
        enor_c     = '0;
        mmax_c     = '0;
        mmin_c     = '0;

        comp_c = (ea_c > eb_c) || ((ea_c == eb_c) && (ma_c >= mb_c));

        if (comp_c) begin
            diff_c = {1'b0, ea_c} - {1'b0, eb_c};
            enor_c = ea_c;
            mmax_c = ma_c;
            mmin_c = mb_c;
        end else begin
            diff_c = {1'b0, eb_c} - {1'b0, ea_c};
            enor_c = eb_c;
            mmax_c = mb_c;
            mmin_c = ma_c;
        end

        if (diff_c > MW_E) begin
            dexp_sat_c = MW_S;
        end else begin
            dexp_sat_c = SW'(diff_c);
        end
    end

    // Stage 1 register: captures the ordered operands on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sa    <= 1'b0;
            s1_sb    <= 1'b0;
            s1_comp  <= 1'b0;
            s1_enor  <= '0;
            s1_mmax  <= '0;
            s1_mmin  <= '0;
            s1_dexp  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s1_adv && in_valid) begin
                s1_sa   <= sign_a_c;
                s1_sb   <= sign_b_c;
                s1_comp <= comp_c;
                s1_enor <= enor_c;
                s1_mmax <= mmax_c;
                s1_mmin <= mmin_c;
                s1_dexp <= dexp_sat_c;
            end
        end
    end

    // Alignment shift with sticky collection of the shifted-out bits
    logic [MW-1:0] shifted_c;
    logic [MW-1:0] lost_mask_c;
    logic          sticky_c;
    logic [MW-1:0] aln_c;

    always_comb begin
        shifted_c   = '0;
        lost_mask_c = '0;
        sticky_c    = 1'b0;
        aln_c       = '0;

        shifted_c   = s1_mmin >> s1_dexp;
        lost_mask_c = ~({MW{1'b1}} << s1_dexp);
        sticky_c    = |(s1_mmin & lost_mask_c);
        aln_c       = {shifted_c[MW-1:1], shifted_c[0] | sticky_c};
    end

    // Stage 2 register: output stage, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            comp     <= 1'b0;
            eff_sub  <= 1'b0;
            enor     <= '0;
            m_max    <= '0;
            m_aln    <= '0;
            dexp     <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_adv && s1_valid) begin
                sa      <= s1_sa;
                sb      <= s1_sb;
                comp    <= s1_comp;
                eff_sub <= s1_sa ^ s1_sb;
                enor    <= s1_enor;
                m_max   <= s1_mmax;
                m_aln   <= aln_c;
                dexp    <= s1_dexp;
            end
        end
    end

endmodule

// File: tb/tb_fp_align_pipe.sv
// Directed self-checking bench for fp_align_pipe (EW=8, MW=28).
module tb_fp_align_pipe;

    localparam int unsigned EW = 8;
    localparam int unsigned MW = 28;
    localparam int unsigned DW = 1 + EW + MW;
    localparam int unsigned SW = $clog2(MW + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          op_sub;
    logic          out_valid;
    logic          out_ready;
    logic          sa;
    logic          sb;
    logic          comp;
    logic          eff_sub;
    logic [EW-1:0] enor;
    logic [MW-1:0] m_max;
    logic [MW-1:0] m_aln;
    logic [SW-1:0] dexp;

    int n_cmp = 0;
    int n_err = 0;

    fp_align_pipe #(.EW(EW), .MW(MW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_sub   (op_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sa       (sa),
        .sb       (sb),
        .comp     (comp),
        .eff_sub  (eff_sub),
        .enor     (enor),
        .m_max    (m_max),
        .m_aln    (m_aln),
        .dexp     (dexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m);
        return {s, e, m};
    endfunction

    // Present one pair for one cycle and return just after the result lands
    task automatic run_single(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub,
                              output logic early_valid);
        @(posedge clk); #1;
        op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        early_valid = out_valid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset.out_valid got %0h want 0", out_valid); end
        n_cmp++; if (m_aln !== '0 || m_max !== '0 || enor !== '0 || dexp !== '0) begin n_err++; $display("FAIL reset.data got aln=%0h max=%0h enor=%0h dexp=%0h want 0", m_aln, m_max, enor, dexp); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset.in_ready got %0h want 1", in_ready); end
    endtask

    task automatic test_align();
        logic early;
        run_single(mk(1'b0, 8'd130, 28'h8000000), mk(1'b0, 8'd128, 28'h8000003), 1'b0, early);
        n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL align.latency early out_valid got %0h want 0", early); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL align.out_valid got %0h want 1", out_valid); end
        n_cmp++; if (comp !== 1'b1) begin n_err++; $display("FAIL align.comp got %0h want 1", comp); end
        n_cmp++; if (enor !== 8'd130) begin n_err++; $display("FAIL align.enor got %0d want 130", enor); end
        n_cmp++; if (dexp !== 5'd2) begin n_err++; $display("FAIL align.dexp got %0d want 2", dexp); end
        n_cmp++; if (m_max !== 28'h8000000) begin n_err++; $display("FAIL align.m_max got %0h want 8000000", m_max); end
        n_cmp++; if (m_aln !== 28'h2000001) begin n_err++; $display("FAIL align.m_aln got %0h want 2000001", m_aln); end
        n_cmp++; if (eff_sub !== 1'b0) begin n_err++; $display("FAIL align.eff_sub got %0h want 0", eff_sub); end
        // B larger by exponent, no bits lost
        run_single(mk(1'b0, 8'd100, 28'h8000010), mk(1'b0, 8'd103, 28'h0000001), 1'b0, early);
        n_cmp++; if (comp !== 1'b0) begin n_err++; $display("FAIL blarge.comp got %0h want 0", comp); end
        n_cmp++; if (enor !== 8'd103 || dexp !== 5'd3) begin n_err++; $display("FAIL blarge.enor_dexp got %0d/%0d want 103/3", enor, dexp); end
        n_cmp++; if (m_max !== 28'h0000001) begin n_err++; $display("FAIL blarge.m_max got %0h want 1", m_max); end
        n_cmp++; if (m_aln !== 28'h1000002) begin n_err++; $display("FAIL blarge.m_aln got %0h want 1000002", m_aln); end
    endtask

    task automatic test_swap();
        logic early;
        run_single(mk(1'b0, 8'd127, 28'h4000000), mk(1'b0, 8'd127, 28'h6000000), 1'b0, early);
        n_cmp++; if (comp !== 1'b0) begin n_err++; $display("FAIL swap.comp got %0h want 0", comp); end
        n_cmp++; if (dexp !== 5'd0) begin n_err++; $display("FAIL swap.dexp got %0d want 0", dexp); end
        n_cmp++; if (m_max !== 28'h6000000) begin n_err++; $display("FAIL swap.m_max got %0h want 6000000", m_max); end
        n_cmp++; if (m_aln !== 28'h4000000) begin n_err++; $display("FAIL swap.m_aln got %0h want 4000000", m_aln); end
        n_cmp++; if (enor !== 8'd127) begin n_err++; $display("FAIL swap.enor got %0d want 127", enor); end
    endtask

    task automatic test_saturate();
        logic early;
        run_single(mk(1'b0, 8'd200, 28'h8000000), mk(1'b0, 8'd100, 28'h0000001), 1'b0, early);
        n_cmp++; if (dexp !== 5'd28) begin n_err++; $display("FAIL sat.dexp got %0d want 28", dexp); end
        n_cmp++; if (m_aln !== 28'h0000001) begin n_err++; $display("FAIL sat.m_aln got %0h want 1", m_aln); end
        n_cmp++; if (enor !== 8'd200 || comp !== 1'b1) begin n_err++; $display("FAIL sat.enor_comp got %0d/%0h want 200/1", enor, comp); end
        run_single(mk(1'b0, 8'd200, 28'h8000000), mk(1'b0, 8'd100, 28'h0000000), 1'b0, early);
        n_cmp++; if (m_aln !== 28'h0) begin n_err++; $display("FAIL sat_zero.m_aln got %0h want 0", m_aln); end
        // difference exactly MW: unsaturated full shift, all bits go to sticky
        run_single(mk(1'b0, 8'd128, 28'h0000100), mk(1'b0, 8'd100, 28'h8000000), 1'b0, early);
        n_cmp++; if (dexp !== 5'd28 || m_aln !== 28'h0000001) begin n_err++; $display("FAIL edge28 got dexp=%0d aln=%0h want 28/1", dexp, m_aln); end
        // difference MW-1: top bit lands in bit 0
        run_single(mk(1'b0, 8'd127, 28'h0000100), mk(1'b0, 8'd100, 28'h8000000), 1'b0, early);
        n_cmp++; if (dexp !== 5'd27 || m_aln !== 28'h0000001) begin n_err++; $display("FAIL edge27 got dexp=%0d aln=%0h want 27/1", dexp, m_aln); end
    endtask

    task automatic test_sub();
        logic early;
        run_single(mk(1'b0, 8'd127, 28'h8000000), mk(1'b0, 8'd127, 28'h8000000), 1'b1, early);
        n_cmp++; if (sa !== 1'b0 || sb !== 1'b1) begin n_err++; $display("FAIL sub.signs got sa=%0h sb=%0h want 0/1", sa, sb); end
        n_cmp++; if (eff_sub !== 1'b1) begin n_err++; $display("FAIL sub.eff_sub got %0h want 1", eff_sub); end
        n_cmp++; if (comp !== 1'b1 || m_aln !== 28'h8000000) begin n_err++; $display("FAIL sub.equal got comp=%0h aln=%0h want 1/8000000", comp, m_aln); end
        run_single(mk(1'b1, 8'd10, 28'h1), mk(1'b1, 8'd9, 28'h1), 1'b1, early);
        n_cmp++; if (sa !== 1'b1 || sb !== 1'b0 || eff_sub !== 1'b1) begin n_err++; $display("FAIL sub2 got sa=%0h sb=%0h eff=%0h want 1/0/1", sa, sb, eff_sub); end
    endtask

    // Five pairs pushed against a 6-cycle stall, then drained in order
    task automatic test_backpressure();
        int idx;
        int rcv;
        logic acc;
        idx = 0;
        rcv = 0;
        for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
            out_ready = (cyc >= 6);
            if (idx < 5) begin
                op_a = mk(1'b0, 8'(120 + idx), 28'(32'h100 * (idx + 1)));
                op_b = mk(1'b0, 8'd120, 28'h0);
                op_sub = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 5) begin
                n_cmp++; if (idx !== 2) begin n_err++; $display("FAIL bp.accepts got %0d want 2", idx); end
                n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp.in_ready got %0h want 0", in_ready); end
                n_cmp++; if (out_valid !== 1'b1 || enor !== 8'd120 || m_max !== 28'h100) begin n_err++; $display("FAIL bp.hold got v=%0h enor=%0d max=%0h want 1/120/100", out_valid, enor, m_max); end
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                n_cmp++; if (enor !== 8'(120 + rcv) || m_max !== 28'(32'h100 * (rcv + 1))) begin n_err++; $display("FAIL bp.order[%0d] got enor=%0d max=%0h want %0d/%0h", rcv, enor, m_max, 120 + rcv, 32'h100 * (rcv + 1)); end
                rcv++;
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        n_cmp++; if (rcv !== 5) begin n_err++; $display("FAIL bp.count got %0d want 5", rcv); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp.drain out_valid got %0h want 0", out_valid); end
    endtask

    // Full-rate stream: one result per cycle, starting two cycles after first accept
    task automatic test_back_to_back();
        int rcv;
        rcv = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc < 4) begin
                op_a = mk(1'b0, 8'd50, 28'h10);
                op_b = mk(1'b0, 8'(46 - cyc), 28'hF);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc < 4) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b.in_ready[%0d] got %0h want 1", cyc, in_ready); end
            end
            if (cyc >= 2) begin
                n_cmp++; if (out_valid !== 1'b1 || dexp !== 5'(4 + rcv)) begin n_err++; $display("FAIL b2b.out[%0d] got v=%0h dexp=%0d want 1/%0d", rcv, out_valid, dexp, 4 + rcv); end
                rcv++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        op_a = mk(1'b0, 8'd77, 28'h123);
        op_b = mk(1'b0, 8'd70, 28'h456);
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL rstmid.full got v=%0h rdy=%0h want 1/0", out_valid, in_ready); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid.async out_valid got %0h want 0", out_valid); end
        n_cmp++; if (enor !== '0 || m_max !== '0) begin n_err++; $display("FAIL rstmid.data got enor=%0h max=%0h want 0", enor, m_max); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid.in_ready got %0h want 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid.stale[%0d] got %0h want 0", i, out_valid); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_sub    = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_align();
        test_swap();
        test_saturate();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
